// File: rtl/fa2_sum_accumulator.sv
// fa2_sum_accumulator: sums SAMPLES adder outputs into a total with sticky overflow; define ACC_SAT_EN to saturate instead of wrap
module fa2_sum_accumulator #(
  parameter int SAMPLES = 4,
  parameter int ACC_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_overflow
);
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DONE = 1'b1;
  logic [0:0] state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_n, total_q, total_d;
  logic [3:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, oflow_q, oflow_d;
  logic [ACC_W:0] sum;
  logic xfer, last;
  assign in_ready = state_q == ACCUM;
  assign out_valid = state_q == DONE;
  assign out_total = total_q;
  assign out_overflow = oflow_q;
  assign xfer = in_valid && in_ready;
  assign last = cnt_q == 4'(SAMPLES - 1);
  assign sum = {1'b0, acc_q} + {{(ACC_W-2){1'b0}}, in_sum};
`ifdef ACC_SAT_EN
  assign acc_n = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign acc_n = sum[ACC_W-1:0];
`endif
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    total_d = total_q;
    oflow_d = oflow_q;
    if (clr) begin
      state_d = ACCUM;
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (xfer) begin
      acc_d = last ? '0 : acc_n;
      cnt_d = last ? '0 : cnt_q + 4'd1;
      ovf_d = ovf_q | sum[ACC_W];
      state_d = last ? DONE : ACCUM;
      total_d = last ? acc_n : total_q;
      oflow_d = last ? ovf_d : oflow_q;
    end else if (out_valid && out_ready) begin
      state_d = ACCUM;
      ovf_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      total_q <= '0;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      total_q <= total_d;
      oflow_q <= oflow_d;
    end
  end
endmodule

// File: tb/tb_fa2_sum_accumulator.sv
// tb_fa2_sum_accumulator: three parameterisations driven in parallel and checked against an integer-sum model
module tb_fa2_sum_accumulator;
  localparam int SM[3] = '{4, 4, 1};
  localparam int WM[3] = '{5, 4, 5};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic [2:0] in_sum = 3'd0;
  logic out_ready = 1'b1;
  logic rdy[3], ov[3], of[3];
  logic [4:0] tot[3];
  logic [3:0] t1;
  int ncmp = 0, nbad = 0;
  int m_cnt[3], m_sum[3], m_tot[3];
  bit m_ov[3], m_of[3];

  always #5 clk = ~clk;

  fa2_sum_accumulator #(.SAMPLES(4), .ACC_W(5)) u0 (.clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_sum(in_sum), .out_valid(ov[0]),
    .out_ready(out_ready), .out_total(tot[0]), .out_overflow(of[0]));
  fa2_sum_accumulator #(.SAMPLES(4), .ACC_W(4)) u1 (.clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_sum(in_sum), .out_valid(ov[1]),
    .out_ready(out_ready), .out_total(t1), .out_overflow(of[1]));
  fa2_sum_accumulator #(.SAMPLES(1), .ACC_W(5)) u2 (.clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(rdy[2]), .in_sum(in_sum), .out_valid(ov[2]),
    .out_ready(out_ready), .out_total(tot[2]), .out_overflow(of[2]));
  assign tot[1] = {1'b0, t1};

  function automatic int reduce(int s, int w);
`ifdef ACC_SAT_EN
    return s > (1 << w) - 1 ? (1 << w) - 1 : s;
`else
    return s % (1 << w);
`endif
  endfunction

  task automatic chk(string n, int a, int e);
    ncmp++;
    if (a != e) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // Model: count accepted samples and keep the true integer sum of the run
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_ov[i] = 0; m_cnt[i] = 0; m_sum[i] = 0; m_tot[i] = 0; m_of[i] = 0;
      end else if (clr) begin
        m_ov[i] = 0; m_cnt[i] = 0; m_sum[i] = 0;
      end else if (!m_ov[i] && in_valid) begin
        m_sum[i] += int'(in_sum);
        m_cnt[i]++;
        if (m_cnt[i] == SM[i]) begin
          m_ov[i] = 1;
          m_tot[i] = reduce(m_sum[i], WM[i]);
          m_of[i] = m_sum[i] > (1 << WM[i]) - 1;
          m_cnt[i] = 0;
          m_sum[i] = 0;
        end
      end else if (m_ov[i] && out_ready) m_ov[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d in_ready", i), int'(rdy[i]), int'(!m_ov[i]));
      chk($sformatf("u%0d out_valid", i), int'(ov[i]), int'(m_ov[i]));
      chk($sformatf("u%0d out_total", i), int'(tot[i]), m_tot[i]);
      chk($sformatf("u%0d out_overflow", i), int'(of[i]), int'(m_of[i]));
    end
  end

  task automatic feed(input logic [2:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_sum = v;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(string n);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s u%0d in_ready", n, i), int'(rdy[i]), 1);
      chk($sformatf("%s u%0d out_valid", n, i), int'(ov[i]), 0);
      chk($sformatf("%s u%0d out_total", n, i), int'(tot[i]), 0);
      chk($sformatf("%s u%0d out_overflow", n, i), int'(of[i]), 0);
    end
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Back-to-back run with immediate consumption
    feed(3'b001); feed(3'b011); feed(3'b100); feed(3'b110);
    idle();
    chk("run1 out_valid", int'(ov[0]), 1);
    chk("run1 in_ready", int'(rdy[0]), 0);
    chk("run1 out_total", int'(tot[0]), 14);
    chk("run1 out_overflow", int'(of[0]), 0);
    @(negedge clk);
    chk("run1 out_valid drop", int'(ov[0]), 0);
    chk("run1 in_ready rise", int'(rdy[0]), 1);
    // Backpressure: result held while 7 is offered
    out_ready = 1'b0;
    feed(3'b001); feed(3'b011); feed(3'b100); feed(3'b110);
    for (int k = 0; k < 5; k++) begin
      feed(3'b111);
      chk("held in_ready", int'(rdy[0]), 0);
      chk("held out_total", int'(tot[0]), 14);
    end
    @(negedge clk);
    out_ready = 1'b1;
    feed(3'b111);
    chk("post-handshake in_ready", int'(rdy[0]), 1);
    feed(3'b111); feed(3'b111); feed(3'b111);
    idle();
    chk("sevens w5 total", int'(tot[0]), 28);
    chk("sevens w5 ovf", int'(of[0]), 0);
`ifdef ACC_SAT_EN
    chk("sevens w4 total", int'(tot[1]), 15);
`else
    chk("sevens w4 total", int'(tot[1]), 12);
`endif
    chk("sevens w4 ovf", int'(of[1]), 1);
    // Abort mid-run, then a clean run
    feed(3'd6); feed(3'd6);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_sum = 3'd5;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    chk("clr out_valid", int'(ov[0]), 0);
    feed(3'd1); feed(3'd1); feed(3'd1); feed(3'd1);
    idle();
    chk("after clr total", int'(tot[0]), 4);
    chk("after clr ovf", int'(of[0]), 0);
    chk("w4 ovf cleared", int'(of[1]), 0);
    chk("w4 after clr total", int'(tot[1]), 4);
    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_sum = 3'($urandom_range(0, 7));
      out_ready = 1'($urandom_range(0, 2) != 0);
      clr = 1'($urandom_range(0, 31) == 0);
    end
    // Single-sample build and async reset while a result is held
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    feed(3'd2);
    idle();
    chk("s1 first out_valid", int'(ov[2]), 1);
    chk("s1 first total", int'(tot[2]), 2);
    feed(3'd5);
    idle();
    out_ready = 1'b0;
    chk("s1 second out_valid", int'(ov[2]), 1);
    chk("s1 second total", int'(tot[2]), 5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("s1 async out_valid", int'(ov[2]), 0);
    check_reset_outputs("held reset");
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
